dm_cache_responder: RTL and testbench
=====================================

Name: dm_cache_responder

Overview:
- Direct-mapped, single-word-line read cache that answers address requests from an upstream initiator (address generator / CPU fetch stage).
- Hits return data with 1-cycle latency. Misses refill from a backing memory over a req/ack interface, then respond.
- Keeps hit and miss statistics counters, visible to the bench and to debug logic.

Parameters:
- ADDR_W, 32, request address width in bits
- DATA_W, 32, data word width
- INDEX_W, 6, number of index bits (64 lines)
- OFFSET_W, 2, byte-offset bits within a word; ignored for lookup
- CNT_W, 16, width of statistics counters

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  initiator presents an address
- req_addr  in  ADDR_W  byte address
- req_ready  out  1  block can accept a request this cycle
- resp_valid  out  1  single-cycle response strobe
- resp_addr  out  ADDR_W  address of the request being answered
- resp_data  out  DATA_W  read data
- resp_hit  out  1  1 = served from cache, 0 = served after refill
- mem_req  out  1  refill request to backing memory
- mem_addr  out  ADDR_W  word-aligned refill address (offset bits = 0)
- mem_ack  in  1  single-cycle pulse; mem_rdata is valid in the same cycle
- mem_rdata  in  DATA_W  refill data
- hit_cnt  out  CNT_W  number of hits
- miss_cnt  out  CNT_W  number of misses

Behaviour:
- Address split: tag = addr[ADDR_W-1 : INDEX_W+OFFSET_W], index = addr[INDEX_W+OFFSET_W-1 : OFFSET_W].
- Storage: valid, tag and data arrays held in registers, read combinationally.
- Reset (rst=0, asynchronous):
  - all valid bits cleared; FSM to IDLE
  - req_ready=1, resp_valid=0, resp_addr=0, resp_data=0, resp_hit=0
  - mem_req=0, mem_addr=0, hit_cnt=0, miss_cnt=0
  - tag and data arrays are not reset.
- FSM states: IDLE, MISS, FILL.
- IDLE:
  - req_ready=1.
  - On accept (req_valid at a rising edge) with a hit (valid[index] and tag match): in the next cycle resp_valid=1, resp_hit=1, resp_data=data[index], resp_addr=req_addr; hit_cnt increments; stay in IDLE.
  - Back-to-back hits therefore sustain 1 response per cycle.
  - On accept with a miss: latch req_addr; mem_req=1 and mem_addr=word-aligned address from the next cycle; miss_cnt increments; go to MISS.
- MISS:
  - req_ready=0; mem_req held at 1 and mem_addr held stable until mem_ack.
  - On mem_ack: write data[index]=mem_rdata, tag[index]=tag, valid[index]=1; drop mem_req next cycle; go to FILL.
- FILL:
  - resp_valid=1, resp_hit=0, resp_data=refilled word, resp_addr=latched address for one cycle; go to IDLE.
  - req_ready returns to 1 in the cycle after FILL.
- resp_valid is a one-cycle pulse and is 0 in every other cycle. resp_* hold their last value when resp_valid=0.
- Miss latency: accept at edge N; mem_req high from N+1; with mem_ack at edge M, resp_valid is high in cycle M+1.
- mem_ack while not in MISS: ignored.
- Counters saturate at all-ones and do not wrap.
- Byte offset is ignored: addresses differing only in the low OFFSET_W bits hit the same line.
- Conflict: a new tag on a valid index overwrites the line; no writeback, read-only cache.
- Reset asserted mid-refill aborts it: mem_req drops immediately (asynchronously), the line is not written, and no response is issued.

Test Plan:
- Reset, then addr 0,1,2,3 on consecutive cycles (memory returns 0xA5A5_0000 after 3-cycle ack) -> addr 0 misses (resp_hit=0, data 0xA5A5_0000, mem_addr=0); addrs 1..3 hit with the same data; hit_cnt=3, miss_cnt=1.
- Incrementing-by-1 addr sweep 0..255 -> 64 misses, 192 hits; every mem_addr has bits[1:0]=0; final hit_cnt=192, miss_cnt=64.
- Conflict: addr 0x0000_0000 then 0x0000_0100 (same index 0, different tag) then 0x0000_0000 -> three misses; third refill re-requests mem_addr 0.
- Hold mem_ack low 20 cycles during a miss -> mem_req and mem_addr stable, req_ready=0, no resp_valid; single response after the ack.
- Drive rst=0 while in MISS -> mem_req=0 without waiting for a clock edge; after release, a repeat of the same addr misses again (line not filled).
- Spurious mem_ack in IDLE, plus force hit_cnt to saturate (2^16+5 hits) -> no state change or response from the stray ack; hit_cnt holds at 0xFFFF.

Source files
------------

// File: rtl/dm_cache_responder.sv
// Direct-mapped, single-word-line read cache with a req/ack refill port.
// Hits answer one cycle after accept; misses refill from backing memory and then answer.
module dm_cache_responder #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned INDEX_W  = 6,
  parameter int unsigned OFFSET_W = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [ADDR_W-1:0] resp_addr,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_hit,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned LINES = 1 << INDEX_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MISS = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;

  logic [1:0]        r_state;
  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES];

  logic              r_resp_valid;
  logic [ADDR_W-1:0] r_resp_addr;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_resp_hit;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] r_miss_addr;
  logic [CNT_W-1:0]  r_hit_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;

  logic [TAG_W-1:0]   w_req_tag;
  logic [INDEX_W-1:0] w_req_idx;
  logic [TAG_W-1:0]   w_miss_tag;
  logic [INDEX_W-1:0] w_miss_idx;
  logic               w_hit;
  logic               w_fill;

  assign w_req_tag  = req_addr[ADDR_W-1:INDEX_W+OFFSET_W];
  assign w_req_idx  = req_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign w_miss_tag = r_miss_addr[ADDR_W-1:INDEX_W+OFFSET_W];
  assign w_miss_idx = r_miss_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign w_hit      = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
  assign w_fill     = (r_state == ST_MISS) && mem_ack;

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_addr  = r_resp_addr;
  assign resp_data  = r_resp_data;
  assign resp_hit   = r_resp_hit;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign hit_cnt    = r_hit_cnt;
  assign miss_cnt   = r_miss_cnt;

  // Tag/data storage is deliberately not reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_miss_idx]  <= w_miss_tag;
      r_data[w_miss_idx] <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_valid      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_addr  <= '0;
      r_resp_data  <= '0;
      r_resp_hit   <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_miss_addr  <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            if (w_hit) begin
              r_resp_valid <= 1'b1;
              r_resp_hit   <= 1'b1;
              r_resp_data  <= r_data[w_req_idx];
              r_resp_addr  <= req_addr;
              if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
            end else begin
              r_miss_addr <= req_addr;
              r_mem_req   <= 1'b1;
              r_mem_addr  <= {req_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
              if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
              r_state     <= ST_MISS;
            end
          end
        end
        ST_MISS: begin
          // The response is launched with the fill so it is visible during FILL.
          if (mem_ack) begin
            r_valid[w_miss_idx] <= 1'b1;
            r_mem_req           <= 1'b0;
            r_resp_valid        <= 1'b1;
            r_resp_hit          <= 1'b0;
            r_resp_data         <= mem_rdata;
            r_resp_addr         <= r_miss_addr;
            r_state             <= ST_FILL;
          end
        end
        ST_FILL: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_cache_responder.sv
// Directed bench for dm_cache_responder with a simple delayed-ack backing memory model.
module tb_dm_cache_responder;

  localparam logic [31:0] BASE = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_addr;
  logic [31:0] resp_data;
  logic        resp_hit;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int checks = 0;
  int errors = 0;

  dm_cache_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_addr (resp_addr),
    .resp_data (resp_data),
    .resp_hit  (resp_hit),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory: acks after ack_delay cycles of mem_req, data = BASE ^ word address.
  int          ack_delay = 3;
  logic        mem_en = 1'b1;
  logic        spur_ack = 1'b0;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata = '0;
  int          m_cnt = 0;

  assign mem_ack   = m_ack | spur_ack;
  assign mem_rdata = spur_ack ? 32'hDEAD_BEEF : m_rdata;

  always @(posedge clk) begin
    if (!mem_req || !mem_en || m_ack) begin
      m_ack <= 1'b0;
      m_cnt <= 0;
    end else if (m_cnt >= ack_delay - 1) begin
      m_ack   <= 1'b1;
      m_rdata <= BASE ^ mem_addr;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  // Response / refill monitor
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        hit;
    logic [31:0] cyc;
  } resp_t;

  resp_t       resp_q[$];
  logic [31:0] refill_q[$];
  logic        mon_en = 1'b1;
  logic        prev_req = 1'b0;
  int          misalign = 0;
  logic [31:0] cyc = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc > 95000) begin
      $display("FAIL watchdog: cycle %0d exceeded budget 95000", cyc);
      $fatal(1);
    end
  end

  always @(negedge clk) begin
    if (mon_en && resp_valid) resp_q.push_back('{resp_addr, resp_data, resp_hit, cyc});
    if (mon_en && mem_req && !prev_req) refill_q.push_back(mem_addr);
    if (mem_req && (mem_addr[1:0] != 2'b00)) misalign++;
    prev_req = mem_req;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    resp_q.delete();
    refill_q.delete();
    misalign = 0;
    @(negedge clk);
  endtask

  // Present addr and return at the negedge following the accepting edge.
  task automatic send(input logic [31:0] addr);
    int b;
    req_valid = 1'b1;
    req_addr  = addr;
    b = 0;
    while (!req_ready && b < 500) begin
      @(negedge clk);
      b++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL send_ready: req_ready=%0b after %0d cycles, need 1", req_ready, b);
    end
    @(negedge clk);
  endtask

  task automatic wait_resp(input int n);
    int b;
    req_valid = 1'b0;
    b = 0;
    while (resp_q.size() < n && b < 500) begin
      @(negedge clk);
      b++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_hit, mem_req} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl: ready/rv/hit/mreq=%b need 1000",
               {req_ready, resp_valid, resp_hit, mem_req});
    end
    checks++;
    if ({resp_addr, resp_data, mem_addr} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h data=%h maddr=%h need 0", resp_addr, resp_data, mem_addr);
    end
    checks++;
    if ({hit_cnt, miss_cnt} !== 32'h0) begin
      errors++;
      $display("FAIL reset_cnt: hit=%0d miss=%0d need 0", hit_cnt, miss_cnt);
    end
    do_reset();
  endtask

  task automatic test_first_line();
    do_reset();
    ack_delay = 3;
    for (int i = 0; i < 4; i++) send(32'(i));
    wait_resp(4);
    checks++;
    if (resp_q.size() != 4) begin
      errors++;
      $display("FAIL first_count: responses=%0d need 4", resp_q.size());
    end else begin
      checks++;
      if (resp_q[0].hit !== 1'b0 || resp_q[0].data !== BASE || resp_q[0].addr !== 32'h0) begin
        errors++;
        $display("FAIL first_miss: hit=%b data=%h addr=%h need 0 %h 0",
                 resp_q[0].hit, resp_q[0].data, resp_q[0].addr, BASE);
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (resp_q[i].hit !== 1'b1 || resp_q[i].data !== BASE || resp_q[i].addr !== 32'(i)) begin
          errors++;
          $display("FAIL first_hit%0d: hit=%b data=%h addr=%h need 1 %h %0d",
                   i, resp_q[i].hit, resp_q[i].data, resp_q[i].addr, BASE, i);
        end
      end
      checks++;
      if (resp_q[3].cyc - resp_q[1].cyc !== 32'd2) begin
        errors++;
        $display("FAIL back_to_back: hit spacing=%0d need 2", resp_q[3].cyc - resp_q[1].cyc);
      end
    end
    checks++;
    if (refill_q.size() != 1 || refill_q[0] !== 32'h0) begin
      errors++;
      $display("FAIL first_refill: refills=%0d need 1 at addr 0", refill_q.size());
    end
    checks++;
    if (hit_cnt !== 16'd3 || miss_cnt !== 16'd1) begin
      errors++;
      $display("FAIL first_cnt: hit=%0d miss=%0d need 3 1", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_sweep();
    int bad;
    int hits;
    do_reset();
    ack_delay = 2;
    for (int i = 0; i < 256; i++) send(32'(i));
    wait_resp(256);
    checks++;
    if (resp_q.size() != 256) begin
      errors++;
      $display("FAIL sweep_count: responses=%0d need 256", resp_q.size());
    end else begin
      bad = 0;
      hits = 0;
      for (int i = 0; i < 256; i++) begin
        if (resp_q[i].hit) hits++;
        if (resp_q[i].addr !== 32'(i) || resp_q[i].data !== (BASE ^ 32'(i & ~3))
            || resp_q[i].hit !== ((i % 4) != 0)) bad++;
      end
      checks++;
      if (bad != 0 || hits != 192) begin
        errors++;
        $display("FAIL sweep_resp: bad=%0d hits=%0d need 0 192", bad, hits);
      end
    end
    checks++;
    if (misalign != 0 || refill_q.size() != 64) begin
      errors++;
      $display("FAIL sweep_memaddr: misaligned=%0d refills=%0d need 0 64", misalign, refill_q.size());
    end
    checks++;
    if (hit_cnt !== 16'd192 || miss_cnt !== 16'd64) begin
      errors++;
      $display("FAIL sweep_cnt: hit=%0d miss=%0d need 192 64", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    ack_delay = 3;
    send(32'h0000_0000);
    send(32'h0000_0100);
    send(32'h0000_0000);
    wait_resp(3);
    checks++;
    if (resp_q.size() != 3 || resp_q[0].hit || resp_q[1].hit || resp_q[2].hit) begin
      errors++;
      $display("FAIL conflict_resp: responses=%0d need 3 misses", resp_q.size());
    end
    checks++;
    if (refill_q.size() != 3 || refill_q[1] !== 32'h100 || refill_q[2] !== 32'h0) begin
      errors++;
      $display("FAIL conflict_refill: refills=%0d need 3 (0,100,0)", refill_q.size());
    end
    checks++;
    if (miss_cnt !== 16'd3 || hit_cnt !== 16'd0) begin
      errors++;
      $display("FAIL conflict_cnt: hit=%0d miss=%0d need 0 3", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_stall();
    int bad;
    do_reset();
    ack_delay = 25;
    send(32'h0000_0042);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req !== 1'b1 || mem_addr !== 32'h40 || req_ready !== 1'b0 || resp_valid !== 1'b0)
        bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold: bad cycles=%0d need 0", bad);
    end
    wait_resp(1);
    repeat (5) @(negedge clk);
    checks++;
    if (resp_q.size() != 1) begin
      errors++;
      $display("FAIL stall_count: responses=%0d need 1", resp_q.size());
    end else begin
      checks++;
      if (resp_q[0].hit !== 1'b0 || resp_q[0].data !== (BASE ^ 32'h40)
          || resp_q[0].addr !== 32'h42) begin
        errors++;
        $display("FAIL stall_resp: hit=%b data=%h addr=%h need 0 %h 42",
                 resp_q[0].hit, resp_q[0].data, resp_q[0].addr, BASE ^ 32'h40);
      end
    end
    ack_delay = 3;
  endtask

  task automatic test_reset_mid_miss();
    do_reset();
    mem_en = 1'b0;
    send(32'h0000_0080);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: mem_req=%b need 1", mem_req);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_async: mem_req=%b ready=%b need 0 1", mem_req, req_ready);
    end
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mem_en = 1'b1;
    checks++;
    if (resp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_noresp: responses=%0d need 0", resp_q.size());
    end
    send(32'h0000_0080);
    wait_resp(1);
    checks++;
    if (resp_q.size() != 1 || resp_q[0].hit !== 1'b0 || miss_cnt !== 16'd1) begin
      errors++;
      $display("FAIL abort_refill: responses=%0d miss_cnt=%0d need 1 miss, miss_cnt 1",
               resp_q.size(), miss_cnt);
    end
  endtask

  task automatic test_spurious_saturate();
    do_reset();
    send(32'h0);
    wait_resp(1);
    resp_q.delete();
    spur_ack = 1'b1;
    @(negedge clk);
    spur_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (resp_q.size() != 0 || mem_req !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL spurious_ack: responses=%0d mem_req=%b ready=%b need 0 0 1",
               resp_q.size(), mem_req, req_ready);
    end
    send(32'h0);
    wait_resp(1);
    checks++;
    if (resp_q.size() != 1 || resp_q[0].hit !== 1'b1 || resp_q[0].data !== BASE) begin
      errors++;
      $display("FAIL spurious_line: responses=%0d need 1 hit with data %h", resp_q.size(), BASE);
    end
    mon_en = 1'b0;
    req_valid = 1'b1;
    req_addr = 32'h0;
    repeat (65541) @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    checks++;
    if (hit_cnt !== 16'hFFFF || miss_cnt !== 16'd1) begin
      errors++;
      $display("FAIL saturate: hit=%h miss=%0d need ffff 1", hit_cnt, miss_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    test_reset();
    test_first_line();
    test_sweep();
    test_conflict();
    test_stall();
    test_reset_mid_miss();
    test_spurious_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
